reg_wb_arbiter: RTL and testbench
=================================

# reg_wb_arbiter

Write-back arbiter that owns the single write port of the register file. It merges fixed-latency ALU results and variable-latency load results from the LSU into one registered write per cycle (`waddr`/`wdata`/`we`). Load results are buffered in a small FIFO and protected against starvation. Optionally, it forwards the in-flight write to the two asynchronous read ports.

## Interface
Parameters:
- `LD_DEPTH`, default 2: load-result FIFO entries (≥1).
- `STARVE_MAX`, default 4: consecutive cycles a non-empty FIFO may lose arbitration before it is forced through (≥1).

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, synchronous, active-low.
- `alu_valid_i` in 1: ALU result present.
- `alu_rd_i` in `reg_addr_t`: ALU destination.
- `alu_data_i` in `data_t`: ALU result.
- `alu_stall_o` out 1: ALU result not taken this cycle; upstream holds it.
- `ld_valid_i` in 1: load result offered.
- `ld_ready_o` out 1: FIFO can accept.
- `ld_rd_i` in `reg_addr_t`: load destination.
- `ld_data_i` in `data_t`: load data.
- `waddr_o` out `reg_addr_t`: register-file write address.
- `wdata_o` out `data_t`: register-file write data.
- `we_o` out 1: register-file write enable.
- `raddr_a_i` in `reg_addr_t`: read port A address (forwarding only).
- `raddr_b_i` in `reg_addr_t`: read port B address (forwarding only).
- `fwd_a_valid_o` out 1: port A forwarding hit.
- `fwd_a_data_o` out `data_t`: port A forwarded data.
- `fwd_b_valid_o` out 1: port B forwarding hit.
- `fwd_b_data_o` out `data_t`: port B forwarded data.

## Operation
- **Load FIFO:** push on `ld_valid_i && ld_ready_o`. `ld_ready_o = (count != LD_DEPTH)`, derived from registered count. Pop when load is granted. Pointers wrap modulo `LD_DEPTH`. Push and pop in the same cycle leave count unchanged.
- **x0 writes:** an ALU result with `alu_rd_i == 0` is consumed and dropped; it does not occupy the slot. A load with rd 0 is popped without asserting `we_o`.
- **Arbitration, two states:**
  - NORMAL: ALU wins when `alu_valid_i && alu_rd_i != 0`. Otherwise the FIFO head wins if non-empty.
  - FORCE: entered when `starve_cnt == STARVE_MAX`. The FIFO head wins; `alu_stall_o = alu_valid_i` (combinational). Returns to NORMAL the next cycle.
- **Starvation counter:** `starve_cnt` increments each cycle the FIFO is non-empty and not granted. It clears on a load grant or when the FIFO is empty, and saturates at `STARVE_MAX`.
- **Stall:** `alu_stall_o` is 0 in NORMAL.
- **Output register:** the granted result is loaded into `waddr_o`/`wdata_o`. `we_o` is 1 only for a granted non-zero rd. With no grant, `we_o` is 0 and addr/data hold.

## Timing
- **Reset** (`rst_ni == 0` at a `clk_i` edge):
  - `we_o`, `waddr_o`, `wdata_o`, `alu_stall_o` and `starve_cnt` all go to 0; FIFO is emptied; state is NORMAL.
  - `ld_ready_o` = 1 from the first cycle after reset.
  - Reset mid-operation discards buffered loads.
- **ALU latency:** result presented in cycle N appears on `we_o` in N+1 (if not stalled).
- **Load latency:** minimum 2 cycles (push in N, grant in N+1, `we_o` in N+2).
- **Throughput:** one register-file write per cycle.
- **Full FIFO:** `ld_ready_o = 0` even if a pop occurs that cycle (no same-cycle refill).

## Configuration
- **`WB_FWD_EN` defined:**
  - `fwd_x_valid_o = we_o && waddr_o != 0 && raddr_x_i == waddr_o`.
  - `fwd_x_data_o = wdata_o`.
  - This lets consumers of the asynchronous register-file read see the write landing at the next edge.
- **`WB_FWD_EN` undefined:** forwarding outputs are tied to 0 and the comparison logic is not generated.

## Structure
- **`common_pkg`:** reuse `reg_addr_t`, `data_t` and `` `NUM_REGS``. Add `wb_state_e` {`WB_NORMAL`, `WB_FORCE`} and `wb_req_t` {rd, data}.
- **Sub-module `wb_fifo`:** parameterised by depth and `wb_req_t`; provides push/pop/full/empty/count.
- **Top level:** holds the arbiter FSM, starvation counter, output register and forwarding.

## Test plan
- **Reset:** hold `rst_ni = 0` 3 cycles with `alu_valid_i = 1` → `we_o = 0`, `ld_ready_o = 1`, outputs 0; the first ALU (rd 5, 0xAAAA_0001) after release → `we_o = 1`, `waddr_o = 5`, `wdata_o = 0xAAAA_0001` one cycle later.
- **x0 drop:** ALU rd 0, data 0xFFFF_FFFF, with FIFO holding a load (rd 3, 0x1234) → load written in that slot, `we_o` never 1 with `waddr_o = 0`.
- **FIFO full:** push 2 loads (rd 7, 8) with ALU valid every cycle → `ld_ready_o = 0` after the second push; a third offered load is held.
- **Starvation (`STARVE_MAX` = 4):** load buffered, ALU valid (rd 1..) continuously → on cycle 5 `alu_stall_o = 1`, load rd 7 written next cycle, the stalled ALU result is written the cycle after.
- **Forwarding (`WB_FWD_EN`):** `we_o = 1`, `waddr_o = 9`, `wdata_o = 0xDEAD_BEEF`, `raddr_a_i = 9`, `raddr_b_i = 0` → `fwd_a_valid_o = 1` with data 0xDEAD_BEEF, `fwd_b_valid_o = 0`.
- **Reset mid-operation:** 2 loads buffered, assert reset 1 cycle → FIFO empty, no write of rd 7/8 after release.

Source files
------------

// File: rtl/reg_wb_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// reg_wb_arbiter_pkg
// Shared types for the write-back arbiter slice. It stands in for the
// project-wide common package: register address / data types sized from
// `NUM_REGS, plus the arbiter state encoding and the buffered write request.
// ----------------------------------------------------------------------------
`ifndef NUM_REGS
`define NUM_REGS 32
`endif

package reg_wb_arbiter_pkg;

  localparam int NUM_REGS   = `NUM_REGS;
  localparam int REG_ADDR_W = $clog2(NUM_REGS);
  localparam int DATA_W     = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     data_t;

  // Arbiter states: NORMAL lets the ALU win, FORCE drains one starved load.
  typedef enum logic [0:0] {
    WB_NORMAL = 1'b0,
    WB_FORCE  = 1'b1
  } wb_state_e;

  // One pending register-file write.
  typedef struct packed {
    reg_addr_t rd;
    data_t     data;
  } wb_req_t;

  // True when the destination is a real (writable) register, i.e. not x0.
  function automatic logic is_live_rd(input reg_addr_t rd);
    return (rd != {REG_ADDR_W{1'b0}});
  endfunction

endpackage

// File: rtl/reg_wb_arbiter_fifo.sv
// ----------------------------------------------------------------------------
// wb_fifo
// Small synchronous FIFO holding load results until they win the write port.
// Head entry is visible combinationally on data_o; pointers wrap modulo DEPTH.
// Push is ignored when full and pop is ignored when empty.
// Ports:
//   clk_i, rst_ni       : clock, synchronous active-low reset (empties FIFO)
//   push_i, data_i      : enqueue request and payload
//   pop_i               : dequeue the head entry
//   data_o              : head entry
//   full_o, empty_o     : occupancy flags
//   count_o             : number of valid entries (0..DEPTH)
// ----------------------------------------------------------------------------
module wb_fifo
  import reg_wb_arbiter_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = wb_req_t,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  T                 data_i,
  input  logic             pop_i,
  output T                 data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // Modulo-DEPTH increment so non-power-of-two depths wrap correctly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign full_o  = (count == CNT_W'(DEPTH));
  assign empty_o = (count == {CNT_W{1'b0}});
  assign count_o = count;
  assign data_o  = mem[rd_ptr];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr <= {PTR_W{1'b0}};
      rd_ptr <= {PTR_W{1'b0}};
      count  <= {CNT_W{1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr] <= data_i;
    end
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// ----------------------------------------------------------------------------
// reg_wb_arbiter
// Owns the single register-file write port. Merges fixed-latency ALU results
// and buffered LSU load results into one registered write per cycle. A load
// that keeps losing to the ALU is forced through after STARVE_MAX losses.
// Optional feature macro: WB_FWD_EN -- when defined, the in-flight write
// (we_o/waddr_o/wdata_o) is forwarded to the two asynchronous read ports;
// otherwise the forwarding outputs are tied to 0.
// Ports:
//   clk_i, rst_ni                  : clock, synchronous active-low reset
//   alu_valid_i/rd_i/data_i        : ALU result; alu_stall_o asks it to hold
//   ld_valid_i/rd_i/data_i         : load result; accepted when ld_ready_o
//   waddr_o, wdata_o, we_o         : registered register-file write
//   raddr_a_i, raddr_b_i           : read addresses used for forwarding
//   fwd_{a,b}_valid_o/data_o       : forwarding hit and data per read port
// ----------------------------------------------------------------------------
module reg_wb_arbiter
  import reg_wb_arbiter_pkg::*;
#(
  parameter int LD_DEPTH   = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      alu_valid_i,
  input  reg_addr_t alu_rd_i,
  input  data_t     alu_data_i,
  output logic      alu_stall_o,
  input  logic      ld_valid_i,
  output logic      ld_ready_o,
  input  reg_addr_t ld_rd_i,
  input  data_t     ld_data_i,
  output reg_addr_t waddr_o,
  output data_t     wdata_o,
  output logic      we_o,
  input  reg_addr_t raddr_a_i,
  input  reg_addr_t raddr_b_i,
  output logic      fwd_a_valid_o,
  output data_t     fwd_a_data_o,
  output logic      fwd_b_valid_o,
  output data_t     fwd_b_data_o
);

  localparam int CNT_W    = $clog2(LD_DEPTH + 1);
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  wb_state_e           state;
  wb_state_e           state_next;
  logic [STARVE_W-1:0] starve_cnt;
  logic [STARVE_W-1:0] starve_next;

  wb_req_t             ld_req;
  wb_req_t             ld_head;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_empty;
  logic                unused_fifo_full;
  logic [CNT_W-1:0]    fifo_count;

  logic                alu_live;
  logic                grant_alu;
  logic                grant_ld;

  assign ld_req.rd   = ld_rd_i;
  assign ld_req.data = ld_data_i;

  // Ready comes only from the registered count, so a full FIFO stays closed
  // even in a cycle where its head is popped.
  assign ld_ready_o = (fifo_count != CNT_W'(LD_DEPTH));
  assign fifo_push  = ld_valid_i && ld_ready_o;
  assign fifo_pop   = grant_ld;

  wb_fifo #(
    .DEPTH (LD_DEPTH),
    .T     (wb_req_t)
  ) u_ld_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .data_i  (ld_req),
    .pop_i   (fifo_pop),
    .data_o  (ld_head),
    .full_o  (unused_fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // An ALU result to x0 is simply accepted and dropped, so it never competes.
  assign alu_live = alu_valid_i && is_live_rd(alu_rd_i);

  // Write-port arbitration and ALU back-pressure.
  always_comb begin
    grant_alu   = 1'b0;
    grant_ld    = 1'b0;
    alu_stall_o = 1'b0;
    case (state)
      WB_NORMAL: begin
        if (alu_live) begin
          grant_alu = 1'b1;
        end else begin
          grant_ld = !fifo_empty;
        end
      end
      WB_FORCE: begin
        grant_ld    = !fifo_empty;
        alu_stall_o = alu_valid_i;
      end
      default: begin
        grant_alu   = 1'b0;
        grant_ld    = 1'b0;
        alu_stall_o = 1'b0;
      end
    endcase
  end

  // Starvation count: consecutive cycles a waiting load lost. FORCE is the
  // registered image of "count reached STARVE_MAX", so the forced grant lands
  // in the very cycle the counter saturates.
  always_comb begin
    if (fifo_empty || grant_ld) begin
      starve_next = {STARVE_W{1'b0}};
    end else if (starve_cnt != STARVE_W'(STARVE_MAX)) begin
      starve_next = starve_cnt + STARVE_W'(1);
    end else begin
      starve_next = starve_cnt;
    end
    if (starve_next == STARVE_W'(STARVE_MAX)) begin
      state_next = WB_FORCE;
    end else begin
      state_next = WB_NORMAL;
    end
  end

  // Arbiter state and starvation counter registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state      <= WB_NORMAL;
      starve_cnt <= {STARVE_W{1'b0}};
    end else begin
      state      <= state_next;
      starve_cnt <= starve_next;
    end
  end

  // Output write register; address/data hold when nothing is granted.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      we_o    <= 1'b0;
      waddr_o <= {REG_ADDR_W{1'b0}};
      wdata_o <= {DATA_W{1'b0}};
    end else if (grant_alu) begin
      we_o    <= 1'b1;
      waddr_o <= alu_rd_i;
      wdata_o <= alu_data_i;
    end else if (grant_ld) begin
      // A load to x0 still leaves the FIFO but never raises we_o.
      we_o    <= is_live_rd(ld_head.rd);
      waddr_o <= ld_head.rd;
      wdata_o <= ld_head.data;
    end else begin
      we_o    <= 1'b0;
      waddr_o <= waddr_o;
      wdata_o <= wdata_o;
    end
  end

`ifdef WB_FWD_EN
  // The write lands at the next edge; readers of the async register file
  // see the old value this cycle, so hand them the pending data instead.
  assign fwd_a_valid_o = we_o && is_live_rd(waddr_o) && (raddr_a_i == waddr_o);
  assign fwd_b_valid_o = we_o && is_live_rd(waddr_o) && (raddr_b_i == waddr_o);
  assign fwd_a_data_o  = wdata_o;
  assign fwd_b_data_o  = wdata_o;
`else
  logic unused_raddr;
  assign unused_raddr  = ^{raddr_a_i, raddr_b_i};
  assign fwd_a_valid_o = 1'b0;
  assign fwd_b_valid_o = 1'b0;
  assign fwd_a_data_o  = {DATA_W{1'b0}};
  assign fwd_b_data_o  = {DATA_W{1'b0}};
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_reg_wb_arbiter
// Directed self-checking bench for reg_wb_arbiter (LD_DEPTH=2, STARVE_MAX=4).
// Inputs change 1 time unit after the rising edge; outputs are compared in
// that same settled window.
// ----------------------------------------------------------------------------
module tb_reg_wb_arbiter;
  import reg_wb_arbiter_pkg::*;

  logic      clk_i = 1'b0;
  logic      rst_ni;
  logic      alu_valid_i;
  reg_addr_t alu_rd_i;
  data_t     alu_data_i;
  logic      alu_stall_o;
  logic      ld_valid_i;
  logic      ld_ready_o;
  reg_addr_t ld_rd_i;
  data_t     ld_data_i;
  reg_addr_t waddr_o;
  data_t     wdata_o;
  logic      we_o;
  reg_addr_t raddr_a_i;
  reg_addr_t raddr_b_i;
  logic      fwd_a_valid_o;
  data_t     fwd_a_data_o;
  logic      fwd_b_valid_o;
  data_t     fwd_b_data_o;

  int passed = 0;
  int total  = 0;

  always #5 clk_i = ~clk_i;

  reg_wb_arbiter #(.LD_DEPTH(2), .STARVE_MAX(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
    .alu_stall_o(alu_stall_o),
    .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o),
    .ld_rd_i(ld_rd_i), .ld_data_i(ld_data_i),
    .waddr_o(waddr_o), .wdata_o(wdata_o), .we_o(we_o),
    .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i),
    .fwd_a_valid_o(fwd_a_valid_o), .fwd_a_data_o(fwd_a_data_o),
    .fwd_b_valid_o(fwd_b_valid_o), .fwd_b_data_o(fwd_b_data_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; alu_valid_i = 1'b1; alu_rd_i = 5'd5; alu_data_i = 32'hAAAA_0001;
    ld_valid_i = 1'b0; ld_rd_i = 5'd0; ld_data_i = 32'h0;
    raddr_a_i = 5'd0; raddr_b_i = 5'd0;
    for (int i = 0; i < 3; i++) step();
    total++; if (we_o !== 1'b0) $display("FAIL reset_we got %0b want 0", we_o); else passed++;
    total++; if (waddr_o !== 5'd0) $display("FAIL reset_waddr got %0d want 0", waddr_o); else passed++;
    total++; if (wdata_o !== 32'h0) $display("FAIL reset_wdata got %h want 0", wdata_o); else passed++;
    total++; if (ld_ready_o !== 1'b1) $display("FAIL reset_ld_ready got %0b want 1", ld_ready_o); else passed++;
    total++; if (alu_stall_o !== 1'b0) $display("FAIL reset_stall got %0b want 0", alu_stall_o); else passed++;
    rst_ni = 1'b1;
    step();
    alu_valid_i = 1'b0;
    total++; if (we_o !== 1'b1) $display("FAIL first_alu_we got %0b want 1", we_o); else passed++;
    total++; if (waddr_o !== 5'd5) $display("FAIL first_alu_waddr got %0d want 5", waddr_o); else passed++;
    total++; if (wdata_o !== 32'hAAAA_0001) $display("FAIL first_alu_wdata got %h want aaaa0001", wdata_o); else passed++;
    step();
    total++; if (we_o !== 1'b0 || waddr_o !== 5'd5) $display("FAIL idle_hold got we=%0b addr=%0d want we=0 addr=5", we_o, waddr_o); else passed++;
  endtask

  task automatic test_x0_drop();
    ld_valid_i = 1'b1; ld_rd_i = 5'd3; ld_data_i = 32'h1234;
    step();
    ld_valid_i = 1'b0;
    alu_valid_i = 1'b1; alu_rd_i = 5'd0; alu_data_i = 32'hFFFF_FFFF;
    total++; if (we_o !== 1'b0) $display("FAIL x0_pre_we got %0b want 0", we_o); else passed++;
    step();
    alu_valid_i = 1'b0;
    total++; if (we_o !== 1'b1 || waddr_o !== 5'd3 || wdata_o !== 32'h1234)
      $display("FAIL x0_load_slot got we=%0b addr=%0d data=%h want 1/3/00001234", we_o, waddr_o, wdata_o);
    else passed++;
    step();
    total++; if (we_o !== 1'b0) $display("FAIL x0_after_we got %0b want 0", we_o); else passed++;
  endtask

  task automatic test_fifo_full();
    // C: ALU 10, load 7 pushed into empty FIFO
    alu_valid_i = 1'b1; alu_rd_i = 5'd10; alu_data_i = 32'h10;
    ld_valid_i = 1'b1; ld_rd_i = 5'd7; ld_data_i = 32'h7;
    total++; if (ld_ready_o !== 1'b1) $display("FAIL full_ready0 got %0b want 1", ld_ready_o); else passed++;
    step();
    // D: ALU 11, load 8 pushed (count 1 -> 2)
    alu_rd_i = 5'd11; alu_data_i = 32'h11; ld_rd_i = 5'd8; ld_data_i = 32'h8;
    total++; if (ld_ready_o !== 1'b1) $display("FAIL full_ready1 got %0b want 1", ld_ready_o); else passed++;
    total++; if (waddr_o !== 5'd10 || we_o !== 1'b1) $display("FAIL full_alu10 got we=%0b addr=%0d want 1/10", we_o, waddr_o); else passed++;
    step();
    // E, F: FIFO full, third load offered and held
    alu_rd_i = 5'd12; alu_data_i = 32'h12; ld_rd_i = 5'd9; ld_data_i = 32'h9;
    total++; if (ld_ready_o !== 1'b0) $display("FAIL full_ready2 got %0b want 0", ld_ready_o); else passed++;
    total++; if (waddr_o !== 5'd11) $display("FAIL full_alu11 got %0d want 11", waddr_o); else passed++;
    step();
    alu_rd_i = 5'd13; alu_data_i = 32'h13;
    total++; if (ld_ready_o !== 1'b0) $display("FAIL full_ready3 got %0b want 0", ld_ready_o); else passed++;
    total++; if (waddr_o !== 5'd12) $display("FAIL full_alu12 got %0d want 12", waddr_o); else passed++;
    step();
    // G: ALU idle, head 7 popped, still no same-cycle refill
    alu_valid_i = 1'b0;
    total++; if (ld_ready_o !== 1'b0) $display("FAIL full_pop_ready got %0b want 0", ld_ready_o); else passed++;
    total++; if (waddr_o !== 5'd13) $display("FAIL full_alu13 got %0d want 13", waddr_o); else passed++;
    step();
    // H: load 9 accepted while 8 pops
    total++; if (we_o !== 1'b1 || waddr_o !== 5'd7 || wdata_o !== 32'h7)
      $display("FAIL full_ld7 got we=%0b addr=%0d data=%h want 1/7/7", we_o, waddr_o, wdata_o);
    else passed++;
    total++; if (ld_ready_o !== 1'b1) $display("FAIL full_ready4 got %0b want 1", ld_ready_o); else passed++;
    step();
    ld_valid_i = 1'b0;
    total++; if (waddr_o !== 5'd8 || wdata_o !== 32'h8) $display("FAIL full_ld8 got addr=%0d data=%h want 8/8", waddr_o, wdata_o); else passed++;
    step();
    total++; if (we_o !== 1'b1 || waddr_o !== 5'd9 || wdata_o !== 32'h9)
      $display("FAIL full_ld9 got we=%0b addr=%0d data=%h want 1/9/9", we_o, waddr_o, wdata_o);
    else passed++;
    step();
    total++; if (we_o !== 1'b0) $display("FAIL full_drained_we got %0b want 0", we_o); else passed++;
  endtask

  task automatic test_starvation();
    ld_valid_i = 1'b1; ld_rd_i = 5'd7; ld_data_i = 32'h7777;
    alu_valid_i = 1'b1; alu_rd_i = 5'd1; alu_data_i = 32'h101;
    step();
    ld_valid_i = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      alu_rd_i = 5'(k + 1); alu_data_i = 32'(k + 1) + 32'h100;
      total++; if (alu_stall_o !== 1'b0) $display("FAIL starve_nostall%0d got %0b want 0", k, alu_stall_o); else passed++;
      total++; if (waddr_o !== 5'(k)) $display("FAIL starve_alu%0d got %0d want %0d", k, waddr_o, k); else passed++;
      step();
    end
    alu_rd_i = 5'd6; alu_data_i = 32'h106;
    total++; if (alu_stall_o !== 1'b1) $display("FAIL starve_stall got %0b want 1", alu_stall_o); else passed++;
    total++; if (waddr_o !== 5'd5) $display("FAIL starve_alu5 got %0d want 5", waddr_o); else passed++;
    step();
    total++; if (alu_stall_o !== 1'b0) $display("FAIL starve_release got %0b want 0", alu_stall_o); else passed++;
    total++; if (we_o !== 1'b1 || waddr_o !== 5'd7 || wdata_o !== 32'h7777)
      $display("FAIL starve_forced_ld got we=%0b addr=%0d data=%h want 1/7/7777", we_o, waddr_o, wdata_o);
    else passed++;
    step();
    alu_valid_i = 1'b0;
    total++; if (we_o !== 1'b1 || waddr_o !== 5'd6 || wdata_o !== 32'h106)
      $display("FAIL starve_held_alu got we=%0b addr=%0d data=%h want 1/6/106", we_o, waddr_o, wdata_o);
    else passed++;
    step();
  endtask

  task automatic test_forwarding();
    alu_valid_i = 1'b1; alu_rd_i = 5'd9; alu_data_i = 32'hDEAD_BEEF;
    step();
    alu_valid_i = 1'b0; raddr_a_i = 5'd9; raddr_b_i = 5'd0;
    #1;
`ifdef WB_FWD_EN
    total++; if (fwd_a_valid_o !== 1'b1 || fwd_a_data_o !== 32'hDEAD_BEEF)
      $display("FAIL fwd_a got v=%0b d=%h want 1/deadbeef", fwd_a_valid_o, fwd_a_data_o);
    else passed++;
    total++; if (fwd_b_valid_o !== 1'b0) $display("FAIL fwd_b got %0b want 0", fwd_b_valid_o); else passed++;
`else
    total++; if (fwd_a_valid_o !== 1'b0 || fwd_a_data_o !== 32'h0)
      $display("FAIL fwd_off_a got v=%0b d=%h want 0/0", fwd_a_valid_o, fwd_a_data_o);
    else passed++;
    total++; if (fwd_b_valid_o !== 1'b0 || fwd_b_data_o !== 32'h0)
      $display("FAIL fwd_off_b got v=%0b d=%h want 0/0", fwd_b_valid_o, fwd_b_data_o);
    else passed++;
`endif
    total++; if (we_o !== 1'b1 || waddr_o !== 5'd9) $display("FAIL fwd_write got we=%0b addr=%0d want 1/9", we_o, waddr_o); else passed++;
    step();
    raddr_a_i = 5'd0;
  endtask

  task automatic test_reset_mid_op();
    alu_valid_i = 1'b1; alu_rd_i = 5'd20; alu_data_i = 32'h20;
    ld_valid_i = 1'b1; ld_rd_i = 5'd7; ld_data_i = 32'h70;
    step();
    alu_rd_i = 5'd21; ld_rd_i = 5'd8; ld_data_i = 32'h80;
    step();
    ld_valid_i = 1'b0; rst_ni = 1'b0;
    total++; if (ld_ready_o !== 1'b0) $display("FAIL mid_full got %0b want 0", ld_ready_o); else passed++;
    step();
    rst_ni = 1'b1; alu_valid_i = 1'b0;
    total++; if (we_o !== 1'b0 || waddr_o !== 5'd0) $display("FAIL mid_reset_out got we=%0b addr=%0d want 0/0", we_o, waddr_o); else passed++;
    total++; if (ld_ready_o !== 1'b1) $display("FAIL mid_reset_ready got %0b want 1", ld_ready_o); else passed++;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (we_o !== 1'b0) $display("FAIL mid_no_write%0d got we=%0b addr=%0d want we=0", i, we_o, waddr_o); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_x0_drop();
    test_fifo_full();
    test_starvation();
    test_forwarding();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
